mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Two-requester round-robin arbiter that shares the 2:1 mux datapath between source a and source b.
- Drives the mux `select`, returns per-requester grants, and registers the muxed output `y` with a `valid` qualifier.
- A hold counter bounds how long one requester can own the mux while the other is waiting.
- Sits directly in front of the 2:1 mux; the mux function is implemented inside the block.

Parameters:
- WIDTH, 1, data width of a, b and y.
- MAX_HOLD, 4, maximum consecutive granted cycles while the other requester is waiting; legal range ≥1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_a  input  1  requester A wants the mux.
- req_b  input  1  requester B wants the mux.
- a  input  WIDTH  data from requester A (mux input when select=0).
- b  input  WIDTH  data from requester B (mux input when select=1).
- select  output  1  registered mux select: 0 = a, 1 = b.
- gnt_a  output  1  registered grant to A.
- gnt_b  output  1  registered grant to B.
- y  output  WIDTH  registered muxed data.
- valid  output  1  y carries granted data.

Behaviour:
- Reset (async, immediate, also mid-operation):
  - state=IDLE, select=0, gnt_a=0, gnt_b=0, y=0, valid=0, hold_cnt=0.
  - last_served=B, so A wins the first tie.
- All state and outputs are registered. Grant latency: a request sampled at edge n gives a grant visible after edge n.
- States: IDLE, OWN_A, OWN_B. gnt_a=1 only in OWN_A; gnt_b=1 only in OWN_B; gnt_a and gnt_b are never both 1.
- IDLE transitions:
  - req_a only -> OWN_A.
  - req_b only -> OWN_B.
  - both -> the requester that is not last_served.
  - neither -> stay in IDLE.
- OWN_A (select=0, gnt_a=1); OWN_B is symmetric with a/b swapped:
  - On entry: hold_cnt=0 and last_served=A.
  - Each granted cycle with req_a=1: hold_cnt increments, saturating at MAX_HOLD-1.
  - req_a=0 and req_b=1 -> OWN_B directly, with no idle bubble.
  - req_a=0 and req_b=0 -> IDLE.
  - req_a=1, req_b=1, hold_cnt==MAX_HOLD-1 -> forced handoff to OWN_B.
  - req_a=1, req_b=0 -> stay in OWN_A indefinitely; no preemption without a competitor.
- select is registered and equals gnt_b whenever a grant is active. In IDLE, select holds its last value to avoid needless toggling.
- Data path, with one cycle of latency from select/inputs to output:
  - y <= select ? b : a, computed from the select and inputs present before the edge.
  - valid <= gnt_a | gnt_b.
  - When valid=0, y still updates; it is don't-care downstream.
- MAX_HOLD=1: under continuous dual requests, ownership alternates every cycle.
- hold_cnt is ceil(log2(MAX_HOLD+1)) bits wide and never wraps.
- Simultaneous request drop and forced handoff in the same cycle: the request-drop rule takes priority; the result is identical in either case.
- A requester must hold req high until granted; there is no request queuing.

Test Plan:
1. Reset: assert rst asynchronously between clock edges -> all outputs go to 0 at once without waiting for clk. Release, then idle 3 cycles -> gnt_a=gnt_b=0, valid=0.
2. Single requester: req_a=1, a=1 from cycle 0 -> gnt_a=1, select=0 after edge 1; y=1, valid=1 after edge 2. Holding req_a for 10 cycles never preempts.
3. Contention, MAX_HOLD=4: req_a=req_b=1 from reset release, a=0, b=1 -> gnt_a for 4 cycles, gnt_b for 4, gnt_a for 4. y follows the 0000 1111 0000 pattern, delayed one cycle from select.
4. Handoff without bubble: in OWN_A, drop req_a while req_b=1 -> gnt_b=1 on the very next cycle; there is never a cycle with both grants 0 or both grants 1.
5. MAX_HOLD=1, both requesting -> gnt_a and gnt_b alternate every cycle; select toggles 0,1,0,1.
6. Reset mid-grant: assert rst during OWN_B with hold_cnt=2 -> immediate IDLE. After release with both requesting, A is granted first (last_served=B).

Source files
------------

// File: rtl/mux_rr_arbiter_if.sv
// Request/data/grant bundle between two requesters and the round-robin 2:1 mux arbiter.
interface mux_rr_arbiter_if #(
  parameter int unsigned WIDTH = 1
);
  logic             req_a;
  logic             req_b;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             select;
  logic             gnt_a;
  logic             gnt_b;
  logic [WIDTH-1:0] y;
  logic             valid;

  modport master (
    output req_a, req_b, a, b,
    input  select, gnt_a, gnt_b, y, valid
  );

  modport slave (
    input  req_a, req_b, a, b,
    output select, gnt_a, gnt_b, y, valid
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter owning a 2:1 mux; MAX_HOLD bounds ownership under contention.
module mux_rr_arbiter #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input logic             clk,
  input logic             rst,
  mux_rr_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_b_q, last_b_d;
  logic             select_q, select_d;
  logic             gnt_a_q, gnt_b_q;
  logic [WIDTH-1:0] y_q;
  logic             valid_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_b_d = last_b_q;
    select_d = select_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_a && bus.req_b) state_d = last_b_q ? OWN_A : OWN_B;
        else if (bus.req_a)         state_d = OWN_A;
        else if (bus.req_b)         state_d = OWN_B;
      end
      OWN_A: begin
        if (!bus.req_a)                        state_d = bus.req_b ? OWN_B : IDLE;
        else if (bus.req_b && cnt_q == CNT_MAX) state_d = OWN_B;
      end
      OWN_B: begin
        if (!bus.req_b)                        state_d = bus.req_a ? OWN_A : IDLE;
        else if (bus.req_a && cnt_q == CNT_MAX) state_d = OWN_A;
      end
      default: state_d = IDLE;
    endcase

    // Entering an owner state restarts the hold count; staying accrues it up to saturation.
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == OWN_A) begin
        last_b_d = 1'b0;
        select_d = 1'b0;
      end else if (state_d == OWN_B) begin
        last_b_d = 1'b1;
        select_d = 1'b1;
      end
    end else if (state_q != IDLE && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_b_q <= 1'b1;
      select_q <= 1'b0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      y_q      <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
      select_q <= select_d;
      gnt_a_q  <= (state_d == OWN_A);
      gnt_b_q  <= (state_d == OWN_B);
      y_q      <= select_q ? bus.b : bus.a;
      valid_q  <= gnt_a_q | gnt_b_q;
    end
  end

  assign bus.select = select_q;
  assign bus.gnt_a  = gnt_a_q;
  assign bus.gnt_b  = gnt_b_q;
  assign bus.y      = y_q;
  assign bus.valid  = valid_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed checks of mux_rr_arbiter with MAX_HOLD=4 and MAX_HOLD=1 instances.
module tb_mux_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.WIDTH(1)) bus4 ();
  mux_rr_arbiter_if #(.WIDTH(1)) bus1 ();

  mux_rr_arbiter #(.WIDTH(1), .MAX_HOLD(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  mux_rr_arbiter #(.WIDTH(1), .MAX_HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for one full cycle, release at a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive4(input logic ra, input logic rb, input logic da, input logic db);
    bus4.req_a = ra; bus4.req_b = rb; bus4.a = da; bus4.b = db;
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    drive4(1'b0, 1'b1, 1'b0, 1'b1);
    do_reset();
    step(); step();
    obs = {bus4.gnt_a, bus4.gnt_b, bus4.select, bus4.valid};
    total_cnt++;
    if (obs !== 4'b0111) $display("FAIL pre_reset_active obs=%b exp=0111", obs);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    obs = {bus4.gnt_a, bus4.gnt_b, bus4.select, bus4.valid};
    total_cnt++;
    if (obs !== 4'b0000 || bus4.y !== 1'b0)
      $display("FAIL async_reset obs=%b y=%b exp=0000 y=0", obs, bus4.y);
    else pass_cnt++;
    drive4(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(); step(); step();
    obs = {bus4.gnt_a, bus4.gnt_b, bus4.select, bus4.valid};
    total_cnt++;
    if (obs !== 4'b0000) $display("FAIL idle_after_reset obs=%b exp=0000", obs);
    else pass_cnt++;
  endtask

  task automatic test_single();
    logic [3:0] obs;
    drive4(1'b1, 1'b0, 1'b1, 1'b0);
    do_reset();
    step();
    obs = {bus4.gnt_a, bus4.gnt_b, bus4.select, bus4.valid};
    total_cnt++;
    if (obs !== 4'b1000) $display("FAIL single_grant obs=%b exp=1000", obs);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus4.y !== 1'b1 || bus4.valid !== 1'b1)
      $display("FAIL single_data y=%b valid=%b exp y=1 valid=1", bus4.y, bus4.valid);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      step();
      obs = {bus4.gnt_a, bus4.gnt_b, bus4.select, bus4.valid};
      total_cnt++;
      if (obs !== 4'b1001) $display("FAIL single_hold cyc=%0d obs=%b exp=1001", i, obs);
      else pass_cnt++;
    end
  endtask

  task automatic test_contention();
    logic [11:0] exp_gb;
    logic prev_sel, prev_g, eg;
    logic [4:0] obs;
    exp_gb = 12'b0000_1111_0000;
    drive4(1'b1, 1'b1, 1'b0, 1'b1);
    do_reset();
    prev_sel = 1'b0;
    prev_g = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      eg = exp_gb[11-k];
      obs = {bus4.gnt_a, bus4.gnt_b, bus4.select, bus4.valid, bus4.y};
      total_cnt++;
      if (obs !== {~eg, eg, eg, prev_g, prev_sel})
        $display("FAIL contention cyc=%0d obs=%b exp=%b", k, obs, {~eg, eg, eg, prev_g, prev_sel});
      else pass_cnt++;
      prev_sel = eg;
      prev_g = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] obs;
    drive4(1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    step(); step();
    drive4(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      obs = {bus4.gnt_a, bus4.gnt_b, bus4.select, bus4.valid};
      total_cnt++;
      if (obs !== 4'b0111) $display("FAIL handoff cyc=%0d obs=%b exp=0111", k, obs);
      else pass_cnt++;
    end
    drive4(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    obs = {bus4.gnt_a, bus4.gnt_b, bus4.select, bus4.valid};
    total_cnt++;
    if (obs !== 4'b1001) $display("FAIL handoff_back obs=%b exp=1001", obs);
    else pass_cnt++;
  endtask

  task automatic test_maxhold1();
    logic eg;
    logic [2:0] obs;
    bus1.req_a = 1'b1; bus1.req_b = 1'b1; bus1.a = 1'b0; bus1.b = 1'b1;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step();
      eg = (k % 2) == 1;
      obs = {bus1.gnt_a, bus1.gnt_b, bus1.select};
      total_cnt++;
      if (obs !== {~eg, eg, eg}) $display("FAIL maxhold1 cyc=%0d obs=%b exp=%b", k, obs, {~eg, eg, eg});
      else pass_cnt++;
    end
    bus1.req_a = 1'b0; bus1.req_b = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    logic [2:0] obs;
    drive4(1'b0, 1'b1, 1'b0, 1'b1);
    do_reset();
    step();
    drive4(1'b1, 1'b1, 1'b0, 1'b1);
    step(); step();
    obs = {bus4.gnt_a, bus4.gnt_b, bus4.select};
    total_cnt++;
    if (obs !== 3'b011) $display("FAIL mid_pre obs=%b exp=011", obs);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    obs = {bus4.gnt_a, bus4.gnt_b, bus4.select};
    total_cnt++;
    if (obs !== 3'b000 || bus4.valid !== 1'b0)
      $display("FAIL mid_reset obs=%b valid=%b exp=000 valid=0", obs, bus4.valid);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      obs = {bus4.gnt_a, bus4.gnt_b, bus4.select};
      total_cnt++;
      if (obs !== ((k < 4) ? 3'b100 : 3'b011))
        $display("FAIL mid_after cyc=%0d obs=%b exp=%b", k, obs, (k < 4) ? 3'b100 : 3'b011);
      else pass_cnt++;
    end
  endtask

  initial begin
    drive4(1'b0, 1'b0, 1'b0, 1'b0);
    bus1.req_a = 1'b0; bus1.req_b = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_maxhold1();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
